prco_mem_stage: RTL

Memory-access/writeback stage of the PRCO core, directly downstream of the ALU. It consumes the ALU's one-cycle `ce_reg` / `ce_ram` strobes and its 16-bit result. It performs the LW/SW data-RAM transaction over a req/ack handshake and produces the single register-file writeback port. While a RAM transaction is in flight it stalls the pipeline through `q_busy`.

---
 rtl/prco_mem_stage_pkg.sv | 44 ++++
 rtl/prco_mem_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prco_mem_stage_pkg.sv
// rtl/prco_mem_stage_pkg.sv - PRCO opcodes, memory-stage FSM states and timeout defaults
package prco_mem_stage_pkg;

    localparam int PRCO_OP_W = 5;

    localparam logic [PRCO_OP_W-1:0] PRCO_OP_NOP  = 5'h00;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_MOVI = 5'h01;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_ADD  = 5'h02;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_SUB  = 5'h03;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_AND  = 5'h04;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_OR   = 5'h05;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_XOR  = 5'h06;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_SHL  = 5'h07;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_SHR  = 5'h08;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_CMP  = 5'h09;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_LW   = 5'h10;
    localparam logic [PRCO_OP_W-1:0] PRCO_OP_SW   = 5'h11;

    localparam int PRCO_MEM_TIMEOUT_DEFAULT = 255;

    // ERR is only reachable when the wait-state timeout is built in.
    typedef enum logic [1:0] {
        PRCO_MEM_S_IDLE = 2'd0,
        PRCO_MEM_S_REQ  = 2'd1,
        PRCO_MEM_S_WB   = 2'd2
`ifdef PRCO_MEM_TIMEOUT_EN
        ,
        PRCO_MEM_S_ERR  = 2'd3
`endif
    } prco_mem_state_t;

    // Wait counter width: wide enough for the limit, clamped to 8..16 bits.
    function automatic int prco_wait_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/prco_mem_stage.sv
// rtl/prco_mem_stage.sv - PRCO memory/writeback stage; optional RAM wait timeout under PRCO_MEM_TIMEOUT_EN
module prco_mem_stage
    import prco_mem_stage_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int REG_SEL_W      = 3,
    parameter int TIMEOUT_CYCLES = PRCO_MEM_TIMEOUT_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce_reg,
    input  logic                 i_ce_ram,
    input  logic [4:0]           i_op,
    input  logic [DATA_W-1:0]    i_result,
    input  logic [DATA_W-1:0]    i_store_data,
    input  logic [REG_SEL_W-1:0] i_dst,
    output logic                 q_busy,
    output logic                 q_mem_req,
    output logic                 q_mem_we,
    output logic [DATA_W-1:0]    q_mem_addr,
    output logic [DATA_W-1:0]    q_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    output logic                 q_wb_en,
    output logic [REG_SEL_W-1:0] q_wb_reg,
    output logic [DATA_W-1:0]    q_wb_data,
    output logic                 q_done,
    output logic                 q_mem_err
);

    prco_mem_state_t      state_q;
    prco_mem_state_t      state_d;
    logic [REG_SEL_W-1:0] dst_q;
    logic                 wb_pend_q;
    logic                 op_is_sw;
    logic                 op_no_wb;
    logic                 take_ram;
    logic                 take_reg;
    logic                 wait_expired;

    assign op_is_sw = (i_op == PRCO_OP_SW);
    assign op_no_wb = op_is_sw || (i_op == PRCO_OP_NOP);
    // The RAM strobe has priority when both arrive together.
    assign take_ram = (state_q == PRCO_MEM_S_IDLE) && i_ce_ram;
    assign take_reg = (state_q == PRCO_MEM_S_IDLE) && i_ce_reg && !i_ce_ram;

`ifdef PRCO_MEM_TIMEOUT_EN
    localparam int                CNT_W     = prco_wait_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Counts REQ cycles spent without an ack; restarts on every new request.
    always_ff @(posedge i_clk) begin
        if (i_reset || take_ram) begin
            wait_cnt_q <= '0;
        end else if ((state_q == PRCO_MEM_S_REQ) && !i_mem_ack) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // The cycle that would bring the count to the limit aborts instead.
    assign wait_expired = (wait_cnt_q == WAIT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wait_expired       = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= PRCO_MEM_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the state-decoded strobes.
    always_comb begin
        state_d   = state_q;
        q_busy    = (state_q != PRCO_MEM_S_IDLE);
        q_mem_req = 1'b0;
        q_wb_en   = 1'b0;
        q_done    = 1'b0;
        q_mem_err = 1'b0;
        case (state_q)
            PRCO_MEM_S_IDLE: begin
                if (take_ram) begin
                    state_d = PRCO_MEM_S_REQ;
                end else if (take_reg) begin
                    state_d = PRCO_MEM_S_WB;
                end
            end
            PRCO_MEM_S_REQ: begin
                q_mem_req = 1'b1;
                if (i_mem_ack) begin
                    state_d = PRCO_MEM_S_WB;
                end else if (wait_expired) begin
`ifdef PRCO_MEM_TIMEOUT_EN
                    state_d = PRCO_MEM_S_ERR;
`endif
                end
            end
            PRCO_MEM_S_WB: begin
                q_done  = 1'b1;
                q_wb_en = wb_pend_q;
                state_d = PRCO_MEM_S_IDLE;
            end
`ifdef PRCO_MEM_TIMEOUT_EN
            PRCO_MEM_S_ERR: begin
                q_done    = 1'b1;
                q_mem_err = 1'b1;
                state_d   = PRCO_MEM_S_IDLE;
            end
`endif
            default: begin
                state_d = PRCO_MEM_S_IDLE;
            end
        endcase
    end

    // Request fields and writeback fields; writeback fields only move when a write is due.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_mem_we    <= 1'b0;
            q_mem_addr  <= '0;
            q_mem_wdata <= '0;
            dst_q       <= '0;
            wb_pend_q   <= 1'b0;
            q_wb_reg    <= '0;
            q_wb_data   <= '0;
        end else if (take_ram) begin
            q_mem_we    <= op_is_sw;
            q_mem_addr  <= i_result;
            q_mem_wdata <= i_store_data;
            dst_q       <= i_dst;
            wb_pend_q   <= !op_is_sw;
        end else if (take_reg) begin
            wb_pend_q <= !op_no_wb;
            if (!op_no_wb) begin
                q_wb_reg  <= i_dst;
                q_wb_data <= i_result;
            end
        end else if ((state_q == PRCO_MEM_S_REQ) && i_mem_ack && !q_mem_we) begin
            q_wb_reg  <= dst_q;
            q_wb_data <= i_mem_rdata;
        end
    end

`ifndef SYNTHESIS
    // Simulation notice for strobes that the stage drops.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            if ((state_q == PRCO_MEM_S_IDLE) && i_ce_reg && i_ce_ram) begin
                $info("prco_mem_stage: ce_reg and ce_ram together, reg strobe dropped");
            end
            if ((state_q != PRCO_MEM_S_IDLE) && (i_ce_reg || i_ce_ram)) begin
                $info("prco_mem_stage: strobe while busy ignored");
            end
        end
    end
`endif

endmodule
